// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 scan-code bytes (E0/F0/E1 prefixes, AA self-test) into per-key held state and make/break events.
// Latency: one inclock cycle from an rx_valid strobe to key_down / event outputs.
// Backpressure: none; every rx_valid strobe is consumed, back-to-back strobes included.
module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h4B, 8'h44, 8'h1B, 8'h1D},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int                      TIMEOUT_CYCLES = 2_500_000,
    localparam int                     IW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                inclock,
    input  logic                resetn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                event_valid,
    output logic [IW-1:0]       event_index,
    output logic                event_make,
    output logic                seq_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_SKIP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic                ev_vld_q, ev_vld_d;
    logic [IW-1:0]       ev_idx_q, ev_idx_d;
    logic                ev_make_q, ev_make_d;
    logic [1:0]          rst_sync_q;
    logic                rst_n_int;

    logic                dec_en;
    logic                dec_ext;
    logic                dec_make;
    logic                is_pfx;
    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] chg;

    // Reset asserts asynchronously and releases synchronously to inclock.
    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // Prefix FSM, skip counter and idle timeout; selects what kind of decode this byte gets.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = (state_q == S_IDLE || rx_valid) ? '0 : tmo_q + 1'b1;
        dec_en   = 1'b0;
        dec_ext  = 1'b0;
        dec_make = 1'b0;
        is_pfx   = (rx_data == 8'hE0) || (rx_data == 8'hF0) || (rx_data == 8'hE1);

        if (rx_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'hE0)      state_d = S_EXT;
                    else if (rx_data == 8'hF0) state_d = S_BRK;
                    else if (rx_data == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end else if (rx_data == 8'hAA || rx_data == 8'hFA || rx_data == 8'hEE ||
                                 rx_data == 8'hFE || rx_data == 8'h00 || rx_data == 8'hFF) begin
                        state_d = S_IDLE;
                    end else begin
                        dec_en   = 1'b1;
                        dec_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) state_d = S_EXTBRK;
                    else if (!is_pfx) begin
                        dec_en   = 1'b1;
                        dec_ext  = 1'b1;
                        dec_make = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rx_data == 8'hE0) state_d = S_EXTBRK;
                    else if (!is_pfx) begin
                        dec_en  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXTBRK: begin
                    if (!is_pfx) begin
                        dec_en  = 1'b1;
                        dec_ext = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (skip_q <= 3'd1) begin
                        skip_d  = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon a stalled prefix; held keys are left as they are.
            state_d = S_IDLE;
            skip_d  = 3'd0;
            tmo_d   = '0;
        end
    end

    // Key table update and event generation; the event reports the lowest key that changed.
    always_comb begin
        key_down_d = key_down_q;
        ev_vld_d   = 1'b0;
        ev_idx_d   = ev_idx_q;
        ev_make_d  = ev_make_q;
        match      = '0;
        chg        = '0;

        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = (rx_data == KEY_CODES[8*i +: 8]) && (dec_ext == KEY_EXT[i]);
        end

        if (rx_valid && state_q == S_IDLE && rx_data == 8'hAA) begin
            key_down_d = '0;
        end else if (dec_en) begin
            chg        = dec_make ? (match & ~key_down_q) : (match & key_down_q);
            key_down_d = dec_make ? (key_down_q | match) : (key_down_q & ~match);
            if (|chg) begin
                ev_vld_d  = 1'b1;
                ev_make_d = dec_make;
                for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                    if (chg[i]) ev_idx_d = IW'(i);
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge inclock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= S_IDLE;
            skip_q     <= 3'd0;
            tmo_q      <= '0;
            key_down_q <= '0;
            ev_vld_q   <= 1'b0;
            ev_idx_q   <= '0;
            ev_make_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            key_down_q <= key_down_d;
            ev_vld_q   <= ev_vld_d;
            ev_idx_q   <= ev_idx_d;
            ev_make_q  <= ev_make_d;
        end
    end

    assign key_down    = key_down_q;
    assign event_valid = ev_vld_q;
    assign event_index = ev_idx_q;
    assign event_make  = ev_make_q;
    assign seq_busy    = (state_q != S_IDLE);

endmodule
